// File: rtl/cache_axi_read_arbiter_if.sv
// Signal bundle between the cache refill paths, the arbiter and the AXI read port.
// The master view is the arbiter itself; the slave view is everything around it.
interface cache_axi_read_arbiter_if;
   logic        inst_ar_valid;
   logic        inst_ar_ready;
   logic [31:0] inst_ar_addr;
   logic [7:0]  inst_ar_len;
   logic        data_ar_valid;
   logic        data_ar_ready;
   logic [31:0] data_ar_addr;
   logic [7:0]  data_ar_len;
   logic [2:0]  data_ar_size;
   logic        inst_r_valid;
   logic        inst_r_ready;
   logic        data_r_valid;
   logic        data_r_ready;
   logic [31:0] req_r_data;
   logic [1:0]  req_r_resp;
   logic        req_r_last;
   logic [3:0]  axi_ar_id;
   logic [31:0] axi_ar_addr;
   logic [7:0]  axi_ar_len;
   logic [2:0]  axi_ar_size;
   logic        axi_ar_valid;
   logic        axi_ar_ready;
   logic [3:0]  axi_r_id;
   logic [31:0] axi_r_data;
   logic [1:0]  axi_r_resp;
   logic        axi_r_last;
   logic        axi_r_valid;
   logic        axi_r_ready;
   logic        beat_err;

   modport master (
      input  inst_ar_valid, inst_ar_addr, inst_ar_len,
      input  data_ar_valid, data_ar_addr, data_ar_len, data_ar_size,
      input  inst_r_ready, data_r_ready,
      input  axi_ar_ready, axi_r_id, axi_r_data, axi_r_resp, axi_r_last, axi_r_valid,
      output inst_ar_ready, data_ar_ready, inst_r_valid, data_r_valid,
      output req_r_data, req_r_resp, req_r_last,
      output axi_ar_id, axi_ar_addr, axi_ar_len, axi_ar_size, axi_ar_valid,
      output axi_r_ready, beat_err
   );

   modport slave (
      output inst_ar_valid, inst_ar_addr, inst_ar_len,
      output data_ar_valid, data_ar_addr, data_ar_len, data_ar_size,
      output inst_r_ready, data_r_ready,
      output axi_ar_ready, axi_r_id, axi_r_data, axi_r_resp, axi_r_last, axi_r_valid,
      input  inst_ar_ready, data_ar_ready, inst_r_valid, data_r_valid,
      input  req_r_data, req_r_resp, req_r_last,
      input  axi_ar_id, axi_ar_addr, axi_ar_len, axi_ar_size, axi_ar_valid,
      input  axi_r_ready, beat_err
   );
endinterface

// File: rtl/cache_axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI read channel between I$ and D$ refills.
// One burst in flight; R beats are steered back to the latched owner.
module cache_axi_read_arbiter #(
   parameter logic [3:0] INST_ID = 4'd0,
   parameter logic [3:0] DATA_ID = 4'd1
) (
   input logic clock,
   input logic reset,
   cache_axi_read_arbiter_if.master bus
);
   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t      state, state_nxt;
   logic        owner_data;
   logic        rr_data;
   logic [31:0] lat_addr;
   logic [7:0]  lat_len;
   logic [3:0]  lat_id;
   logic [2:0]  lat_size;
   logic [7:0]  beat_cnt;
   logic        err;
   logic        grant_inst, grant_data, r_hs, beat_bad;

   assign grant_inst = bus.inst_ar_valid && (!bus.data_ar_valid || !rr_data);
   assign grant_data = bus.data_ar_valid && (!bus.inst_ar_valid || rr_data);
   assign beat_bad   = (bus.axi_r_last && (beat_cnt != lat_len)) ||
                       (!bus.axi_r_last && (beat_cnt == lat_len)) ||
                       (bus.axi_r_id != lat_id);
   assign bus.beat_err = err;

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Everything outside the active phase is forced to zero so idle outputs are clean.
   always_comb begin
      state_nxt         = state;
      bus.inst_ar_ready = 1'b0;
      bus.data_ar_ready = 1'b0;
      bus.axi_ar_valid  = 1'b0;
      bus.axi_ar_id     = 4'd0;
      bus.axi_ar_addr   = 32'd0;
      bus.axi_ar_len    = 8'd0;
      bus.axi_ar_size   = 3'd0;
      bus.axi_r_ready   = 1'b0;
      bus.inst_r_valid  = 1'b0;
      bus.data_r_valid  = 1'b0;
      bus.req_r_data    = 32'd0;
      bus.req_r_resp    = 2'd0;
      bus.req_r_last    = 1'b0;
      r_hs              = 1'b0;
      case (state)
         IDLE: begin
            bus.inst_ar_ready = grant_inst;
            bus.data_ar_ready = grant_data;
            if (grant_inst || grant_data) state_nxt = ADDR;
         end
         ADDR: begin
            bus.axi_ar_valid = 1'b1;
            bus.axi_ar_id    = lat_id;
            bus.axi_ar_addr  = lat_addr;
            bus.axi_ar_len   = lat_len;
            bus.axi_ar_size  = lat_size;
            if (bus.axi_ar_ready) state_nxt = DATA;
         end
         DATA: begin
            bus.axi_r_ready  = owner_data ? bus.data_r_ready : bus.inst_r_ready;
            bus.inst_r_valid = !owner_data && bus.axi_r_valid;
            bus.data_r_valid = owner_data && bus.axi_r_valid;
            bus.req_r_data   = bus.axi_r_data;
            bus.req_r_resp   = bus.axi_r_resp;
            bus.req_r_last   = bus.axi_r_last;
            r_hs             = bus.axi_r_valid && bus.axi_r_ready;
            if (r_hs && bus.axi_r_last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         owner_data <= 1'b0;
         rr_data    <= 1'b0;
         lat_addr   <= 32'd0;
         lat_len    <= 8'd0;
         lat_id     <= 4'd0;
         lat_size   <= 3'd0;
         beat_cnt   <= 8'd0;
         err        <= 1'b0;
      end else begin
         case (state)
            IDLE: if (grant_inst || grant_data) begin
               owner_data <= grant_data;
               lat_addr   <= grant_data ? bus.data_ar_addr : bus.inst_ar_addr;
               lat_len    <= grant_data ? bus.data_ar_len  : bus.inst_ar_len;
               lat_id     <= grant_data ? DATA_ID : INST_ID;
               lat_size   <= grant_data ? bus.data_ar_size : 3'b010;
            end
            ADDR: if (bus.axi_ar_ready) beat_cnt <= 8'd0;
            DATA: if (r_hs) begin
               if (beat_cnt != 8'hFF) beat_cnt <= beat_cnt + 8'd1;
               // A bad beat is flagged but still delivered to the owner.
               if (beat_bad) err <= 1'b1;
               if (bus.axi_r_last) rr_data <= !owner_data;
            end
            default: ;
         endcase
      end
   end
endmodule
